// File: rtl/stream_packet_builder_pkg.sv
// Shared definitions for the packet builder: header layout, FSM states, beat format.
package stream_packet_builder_pkg;

    localparam int unsigned STREAM_W = 64;
    localparam int unsigned KEEP_W   = STREAM_W / 8;

    // Header beat layout: byte length in the low bits, destination above it.
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned DEST_LSB = 16;

    typedef enum logic [1:0] {
        StFill,
        StDrop,
        StHeader,
        StDrain
    } state_e;

    // One buffered payload beat as stored in the packet RAM.
    typedef struct packed {
        logic [KEEP_W-1:0]   keep;
        logic [STREAM_W-1:0] data;
    } beat_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_packet_builder_pkt_buf_ram.sv
// Simple dual-port payload buffer with a registered one-cycle read port.
module stream_packet_builder_pkt_buf_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 72,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port plus registered read; a same-cycle write to the read address is
    // passed through so a single-beat packet is already prefetched for draining.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o <= wdata_i;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/stream_packet_builder.sv
// Buffers one whole payload packet, then emits a header beat (length + destination)
// followed by the unmodified payload beats.
module stream_packet_builder
    import stream_packet_builder_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned DEST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic [STREAM_W-1:0]   stream_in_DATA,
    input  logic [KEEP_W-1:0]     stream_in_KEEP,
    input  logic                  stream_in_LAST,
    input  logic                  stream_in_VALID,
    output logic                  stream_in_READY,
    output logic [STREAM_W-1:0]   stream_out_DATA,
    output logic [KEEP_W-1:0]     stream_out_KEEP,
    output logic                  stream_out_LAST,
    output logic                  stream_out_VALID,
    input  logic                  stream_out_READY,
    output logic                  err_oversize
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Write pointer needs one extra bit to hold a full DEPTH-beat count.
    localparam int unsigned PW = AW + 1;

    state_e                state_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LEN_W-1:0]      byte_cnt_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [STREAM_W-1:0]   out_data_q;
    logic [KEEP_W-1:0]     out_keep_q;
    logic                  err_q;

    logic                  in_fire;
    logic                  out_fire;
    logic                  ram_we;
    logic                  rd_advance;
    logic [AW-1:0]         rd_addr;
    logic                  first_beat;
    logic                  at_limit;
    logic                  last_load;
    logic [LEN_W-1:0]      byte_cnt_d;
    logic [DEST_WIDTH-1:0] hdr_dest;
    logic [STREAM_W-1:0]   hdr_data;
    beat_t                 wr_beat;
    beat_t                 rd_beat;

    // Handshakes, buffer addressing and the header word for the packet being closed.
    always_comb begin
        in_fire    = stream_in_VALID & in_ready_q;
        out_fire   = out_valid_q & stream_out_READY;
        ram_we     = in_fire && (state_q == StFill);
        wr_beat    = '{keep: stream_in_KEEP, data: stream_in_DATA};
        first_beat = (wr_ptr_q == '0);
        at_limit   = (wr_ptr_q == PW'(DEPTH - 1));
        byte_cnt_d = byte_cnt_q + LEN_W'(popcount8(stream_in_KEEP));
        // rd_ptr_q names the beat currently sitting in the RAM read register; step the
        // read address whenever that beat moves into the output register.
        rd_advance = out_fire && !((state_q == StDrain) && out_last_q);
        rd_addr    = rd_ptr_q + AW'(rd_advance);
        last_load  = ((PW'(rd_ptr_q) + PW'(1)) == wr_ptr_q);
        hdr_dest   = first_beat ? dest_in : dest_q;
        hdr_data   = '0;
        hdr_data[LEN_LSB +: LEN_W]       = byte_cnt_d;
        hdr_data[DEST_LSB +: DEST_WIDTH] = hdr_dest;
    end

    stream_packet_builder_pkt_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_pkt_buf_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_addr),
        .rdata_o (rd_beat)
    );

    // Packet FSM with counters and the registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            dest_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            in_ready_q <= in_ready_q | (state_q == StFill) | (state_q == StDrop);
            unique case (state_q)
                StFill: begin
                    if (in_fire) begin
                        wr_ptr_q   <= wr_ptr_q + 1'b1;
                        byte_cnt_q <= byte_cnt_d;
                        if (first_beat) begin
                            dest_q <= dest_in;
                        end
                        if (stream_in_LAST) begin
                            state_q     <= StHeader;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= hdr_data;
                            out_keep_q  <= '1;
                            out_last_q  <= 1'b0;
                        end else if (at_limit) begin
                            state_q <= StDrop;
                        end
                    end
                end
                StDrop: begin
                    if (in_fire && stream_in_LAST) begin
                        state_q    <= StFill;
                        err_q      <= 1'b1;
                        wr_ptr_q   <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                StHeader: begin
                    if (out_fire) begin
                        state_q    <= StDrain;
                        out_data_q <= rd_beat.data;
                        out_keep_q <= rd_beat.keep;
                        out_last_q <= last_load;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            state_q     <= StFill;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            out_keep_q  <= '0;
                            wr_ptr_q    <= '0;
                            rd_ptr_q    <= '0;
                            byte_cnt_q  <= '0;
                        end else begin
                            out_data_q <= rd_beat.data;
                            out_keep_q <= rd_beat.keep;
                            out_last_q <= last_load;
                            rd_ptr_q   <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    assign stream_in_READY  = in_ready_q;
    assign stream_out_VALID = out_valid_q;
    assign stream_out_DATA  = out_data_q;
    assign stream_out_KEEP  = out_keep_q;
    assign stream_out_LAST  = out_last_q;
    assign err_oversize     = err_q;

endmodule
